// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory responder
package mips_mem_pkg;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  // Misaligned or beyond the backing array
  function automatic logic access_err(input logic [MEM_WORD_W-1:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) || (addr[MEM_WORD_W-1:2] >= 30'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between EX/MEM and the data memory
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [MEM_WORD_W-1:0] req_addr;
  logic [MEM_WORD_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic [MEM_WORD_W-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word array with registered read
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder: FSM, wait counter, error check
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [MEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  arr_we;
  logic [MEM_WORD_W-1:0] arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[AW+1:2];
          wdata_d = bus.req_wdata;
          err_d   = access_err(bus.req_addr, DEPTH_WORDS) ? ERR_ACCESS : ERR_NONE;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d values already hold the captured request on the edge entering RESP,
  // including the LATENCY=0 case where capture and entry share an edge.
  assign arr_we = (state_d == RESP) && (state_q != RESP) && we_d
                  && (err_d == ERR_NONE) && !rst;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (idx_d),
    .wdata (wdata_d),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = bus.rsp_valid && (err_q == ERR_ACCESS);
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && (err_q == ERR_NONE)) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder (LATENCY=2 and LATENCY=0 builds)
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder_if ifc0 ();
  dmem_responder_if ifc1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst0), .bus(ifc0.slave));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut1 (.clk(clk), .rst(rst1), .bus(ifc1.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int w, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      ifc0.req_valid = v; ifc0.req_we = we; ifc0.req_addr = a; ifc0.req_wdata = d;
    end else begin
      ifc1.req_valid = v; ifc1.req_we = we; ifc1.req_addr = a; ifc1.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? ifc0.req_ready : ifc1.req_ready;
  endfunction
  function automatic logic get_rvalid(input int w);
    return (w == 0) ? ifc0.rsp_valid : ifc1.rsp_valid;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? ifc0.rsp_err : ifc1.rsp_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int w);
    return (w == 0) ? ifc0.rsp_rdata : ifc1.rsp_rdata;
  endfunction

  // Called at the first negedge after the accept edge; k counts negedges from accept
  task automatic wait_rsp(input int w, output int k);
    k = 1;
    while (!get_rvalid(w) && k < 40) begin
      check_eq("ready_busy", 32'(get_ready(w)), 32'd0);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic txn(input int w, input bit we, input logic [31:0] a, input logic [31:0] d);
    int          lat;
    int          k;
    bit          e;
    logic [31:0] exp_rd;
    lat    = (w == 0) ? 2 : 0;
    e      = (a % 4 != 0) || (a / 4 >= DEPTH);
    exp_rd = (we || e) ? 32'd0 : model[w][a / 4];
    @(negedge clk);
    check_eq("ready_idle", 32'(get_ready(w)), 32'd1);
    drive(w, 1'b1, we, a, d);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
    wait_rsp(w, k);
    check_eq("latency", 32'(k), 32'(lat + 1));
    check_eq("rsp_err", 32'(get_err(w)), 32'(e));
    check_eq("rsp_rdata", get_rdata(w), exp_rd);
    check_eq("ready_resp", 32'(get_ready(w)), 32'd0);
    if (we && !e) model[w][a / 4] = d;
    @(negedge clk);
    check_eq("rsp_valid_drop", 32'(get_rvalid(w)), 32'd0);
    check_eq("rdata_idle", get_rdata(w), 32'd0);
    check_eq("ready_again", 32'(get_ready(w)), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  initial begin
    int k;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check_eq("rst_ready", 32'(get_ready(w)), 32'd1);
      check_eq("rst_rvalid", 32'(get_rvalid(w)), 32'd0);
      check_eq("rst_rdata", get_rdata(w), 32'd0);
      check_eq("rst_err", 32'(get_err(w)), 32'd0);
    end

    // Give every word a known value so all later reads are predictable
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++)
        txn(w, 1'b1, 32'(i * 4), $urandom);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h13, 32'h0);
    txn(0, 1'b1, 32'h400, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h0, 32'h0);

    // req_valid held high across two reads; address change during WAIT must not leak
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_rsp(0, k);
    check_eq("b2b_lat1", 32'(k), 32'd3);
    check_eq("b2b_rdata1", get_rdata(0), model[0][4]);
    @(negedge clk);
    check_eq("b2b_ready4", 32'(get_ready(0)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, k);
    check_eq("b2b_lat2", 32'(k), 32'd3);
    check_eq("b2b_rdata2", get_rdata(0), model[0][17]);
    @(negedge clk);

    // Reset in the first WAIT cycle of a write: no response, no commit
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("rstwait_no_rsp", 32'(get_rvalid(0)), 32'd0);
      @(negedge clk);
    end
    txn(0, 1'b0, 32'h20, 32'h0);

    // Reset and req_valid together: the request must be dropped
    @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("rstreq_ready", 32'(get_ready(0)), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("rstreq_no_rsp", 32'(get_rvalid(0)), 32'd0);
      @(negedge clk);
    end

    for (int n = 0; n < 200; n++) begin
      int w;
      w = $urandom_range(0, 1);
      txn(w, 1'($urandom), rand_addr(), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
